// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Both handshake outputs decode registered state only, so no ready path runs through the stage.
module pipe_skid_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             accept;
    logic             drain;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_q;
    assign occupancy = state_q;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Flush wins over every handshake; data registers keep stale contents, only state clears.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios plus a long random valid/ready run.
// A negedge monitor owns the reference queue and compares handshake outputs and drained words.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  occupancy;

    int          passed;
    int          total;
    logic [15:0] exp_q[$];
    logic        stall_prev;
    logic [15:0] stall_data;

    pipe_skid_reg #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Inputs change 1 time unit after a posedge and stay stable for the next one.
    task automatic drive(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic peek(input string name, input logic v, input logic r,
                        input logic [1:0] o, input logic [15:0] d, input logic use_d);
        #1;
        chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, r});
        chk({name, ".occupancy"}, {30'd0, occupancy}, {30'd0, o});
        if (use_d) chk({name, ".out_data"}, {16'd0, out_data}, {16'd0, d});
    endtask

    // Reference model: advances the expected contents for the upcoming posedge.
    always @(negedge clk) begin
        logic        can_acc;
        logic [15:0] w;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            chk("mon.out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            chk("mon.in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() != 2});
            chk("mon.occupancy", {30'd0, occupancy}, exp_q.size());
            if (stall_prev) chk("mon.stall_data", {16'd0, out_data}, {16'd0, stall_data});
            stall_prev = out_valid && !out_ready && !flush;
            stall_data = out_data;
            if (flush) begin
                exp_q.delete();
            end else begin
                can_acc = (exp_q.size() != 2);
                if (exp_q.size() != 0 && out_ready) begin
                    w = exp_q.pop_front();
                    chk("mon.drain_data", {16'd0, out_data}, {16'd0, w});
                end
                if (in_valid && can_acc) exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        stall_prev = 1'b0;
        #6;
        peek("reset", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1);
        #6 rst_n = 1'b1;

        // Streaming: one word per cycle through the stage.
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, i[15:0], 1'b1, 1'b0);
            if (i > 1) peek("stream", 1'b1, 1'b1, 2'd1, i[15:0] - 16'd1, 1'b1);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        peek("stream_last", 1'b1, 1'b1, 2'd1, 16'h0010, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        peek("stream_empty", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);

        // Backpressure into the skid entry.
        drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
        drive(1'b1, 16'h5555, 1'b0, 1'b0);
        peek("bp_busy", 1'b1, 1'b1, 2'd1, 16'hAAAA, 1'b1);
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        peek("bp_full", 1'b1, 1'b0, 2'd2, 16'hAAAA, 1'b1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        peek("bp_hold", 1'b1, 1'b0, 2'd2, 16'hAAAA, 1'b1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        peek("bp_second", 1'b1, 1'b1, 2'd1, 16'h5555, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        peek("bp_empty", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);

        // Flush while full, with a word offered in the same cycle.
        drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
        drive(1'b1, 16'hCAFE, 1'b0, 1'b0);
        drive(1'b1, 16'h7777, 1'b0, 1'b1);
        peek("fl_full", 1'b1, 1'b0, 2'd2, 16'hBEEF, 1'b1);
        drive(1'b1, 16'h0042, 1'b0, 1'b0);
        peek("fl_empty", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        peek("fl_alone", 1'b1, 1'b1, 2'd1, 16'h0042, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        peek("fl_done", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);

        // Flush while busy with in_ready high: the offered word is dropped.
        drive(1'b1, 16'h1357, 1'b0, 1'b0);
        drive(1'b1, 16'h2468, 1'b1, 1'b1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        peek("flb_empty", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);

        // Asynchronous reset mid-cycle while full.
        drive(1'b1, 16'h1111, 1'b0, 1'b0);
        drive(1'b1, 16'h2222, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        peek("rst_pre", 1'b1, 1'b0, 2'd2, 16'h1111, 1'b1);
        #1 rst_n = 1'b0;
        peek("rst_async", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Random valid/ready with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        peek("final", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("final.queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
